// File: rtl/mac_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_stage
// Purpose  : Streaming multiply-accumulate back end. Takes one 64-bit signed
//            product per beat from the upstream multiplier, sums a group of
//            beats (dot product) into an ACC_W-bit accumulator and presents
//            the group sum, beat count and sticky signed-overflow flag on a
//            valid/ready output. A drain and the first beat of the next group
//            may share one clock edge, so groups stream with no bubble.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   product beat present
//            in_ready   stage can accept a beat
//            in_product signed product (64 bits)
//            in_last    beat closes the current group
//            out_valid  group result available
//            out_ready  consumer accepts result
//            out_acc    signed accumulated sum (ACC_W bits)
//            out_count  beats in the group (CNT_W bits)
//            out_ovf    sticky signed overflow within the group
// Options  : MAC_ACCUM_SATURATE_EN - clamp the accumulator on overflow
//            instead of wrapping modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accum_stage #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  // Holds in_ready low until the first clock after reset release.
  logic             alive_q;

  logic [ACC_W-1:0] w_prod_x;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_add;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_ovf_now;
  logic             w_close_first;
  logic             w_close_next;

  generate
    if (ACC_W > 64) begin : g_ext_wide
      assign w_prod_x = {{(ACC_W-64){in_product[63]}}, in_product};
    end else begin : g_ext_exact
      assign w_prod_x = in_product;
    end
  endgenerate

  assign w_sum     = acc_q + w_prod_x;
  // Equal operand signs with a differing result sign is a signed overflow.
  assign w_ovf_now = (acc_q[ACC_W-1] == w_prod_x[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Overflow direction follows the (shared) operand sign.
  assign w_acc_add = !w_ovf_now     ? w_sum :
                     acc_q[ACC_W-1] ? C_ACC_MIN : C_ACC_MAX;
`else
  assign w_acc_add = w_sum;
`endif

  assign w_cnt_inc     = cnt_q + C_CNT_ONE;
  // A group is force-closed on beat 2^CNT_W-1 so the counter never wraps.
  assign w_close_first = in_last || (C_CNT_ONE == C_CNT_MAX);
  assign w_close_next  = in_last || (w_cnt_inc == C_CNT_MAX);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          acc_d   = w_prod_x;
          cnt_d   = C_CNT_ONE;
          ovf_d   = 1'b0;
          state_d = w_close_first ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = w_acc_add;
          cnt_d   = w_cnt_inc;
          ovf_d   = ovf_q | w_ovf_now;
          state_d = w_close_next ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // Drain and first beat of the next group on the same edge.
            acc_d   = w_prod_x;
            cnt_d   = C_CNT_ONE;
            ovf_d   = 1'b0;
            state_d = w_close_first ? ST_HOLD : ST_ACCUM;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      alive_q <= 1'b1;
    end
  end

  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accum_stage
// Purpose  : Self-checking bench for mac_accum_stage. Three instances:
//            a_* default (ACC_W=72, CNT_W=8), b_* ACC_W=64, c_* CNT_W=2.
//            Expected values come from directed constants and an
//            arbitrary-precision reference adder (128-bit arithmetic with
//            explicit range checks).
// Options  : MAC_ACCUM_SATURATE_EN - selects saturating expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accum_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_last, a_out_ready, a_in_ready, a_out_valid, a_out_ovf;
  logic [63:0] a_in_product;
  logic [71:0] a_out_acc;
  logic [7:0]  a_out_count;

  logic        b_in_valid, b_in_last, b_out_ready, b_in_ready, b_out_valid, b_out_ovf;
  logic [63:0] b_in_product;
  logic [63:0] b_out_acc;
  logic [7:0]  b_out_count;

  logic        c_in_valid, c_in_last, c_out_ready, c_in_ready, c_out_valid, c_out_ovf;
  logic [63:0] c_in_product;
  logic [71:0] c_out_acc;
  logic [1:0]  c_out_count;

  mac_accum_stage #(.ACC_W(72), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_product(a_in_product), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_acc(a_out_acc), .out_count(a_out_count),
    .out_ovf(a_out_ovf));

  mac_accum_stage #(.ACC_W(64), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_product(b_in_product), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_acc(b_out_acc), .out_count(b_out_count),
    .out_ovf(b_out_ovf));

  mac_accum_stage #(.ACC_W(72), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_product(c_in_product), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_acc(c_out_acc), .out_count(c_out_count),
    .out_ovf(c_out_ovf));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the random scenario.
  logic signed [127:0] m_acc, r_acc;
  int                  m_cnt, r_cnt;
  logic                m_ovf, r_ovf, m_open, m_pend;

  // Exact signed add, then fold back into a w-bit signed range.
  function automatic logic signed [127:0] m_add(input logic signed [127:0] acc,
                                                input logic signed [63:0] p,
                                                input int w, output logic ovf);
    logic signed [127:0] span, hi, lo, ex;
    span = 128'sd1;
    span = span << w;
    hi   = (span >>> 1) - 128'sd1;
    lo   = -(span >>> 1);
    ex   = acc + p;
    ovf  = 1'b0;
    if (ex > hi) begin
      ovf = 1'b1;
`ifdef MAC_ACCUM_SATURATE_EN
      ex = hi;
`else
      ex = ex - span;
`endif
    end else if (ex < lo) begin
      ovf = 1'b1;
`ifdef MAC_ACCUM_SATURATE_EN
      ex = lo;
`else
      ex = ex + span;
`endif
    end
    return ex;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_in_valid = 1'b0; a_in_last = 1'b0; a_in_product = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_product = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_last = 1'b0; c_in_product = '0; c_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    step();
    step();
    n_checks++;
    if ({a_out_valid, a_out_ovf, a_in_ready} !== 3'b000) $display("FAIL rst_a_flags: got %b want 000", {a_out_valid, a_out_ovf, a_in_ready});
    else n_pass++;
    n_checks++;
    if ({a_out_count, a_out_acc} !== 80'h0) $display("FAIL rst_a_data: got cnt=%h acc=%h want 0", a_out_count, a_out_acc);
    else n_pass++;
    n_checks++;
    if ({b_out_valid, b_in_ready, c_out_valid, c_in_ready} !== 4'b0000) $display("FAIL rst_bc_flags: got %b want 0000", {b_out_valid, b_in_ready, c_out_valid, c_in_ready});
    else n_pass++;
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (a_in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", a_in_ready);
    else n_pass++;
    a_in_valid = 1'b1; a_in_product = 64'hFFFF_FFFF_FFFF_FFFA; a_in_last = 1'b1;
    step();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_ovf, a_out_count} !== {1'b1, 1'b0, 8'd1}) $display("FAIL single_flags: got v=%b o=%b c=%0d want v=1 o=0 c=1", a_out_valid, a_out_ovf, a_out_count);
    else n_pass++;
    n_checks++;
    if (a_out_acc !== 72'hFF_FFFF_FFFF_FFFF_FFFA) $display("FAIL single_acc: got %h want ffffffffffffffffa", a_out_acc);
    else n_pass++;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL single_drain: got out_valid=%b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] beats [4];
    beats[0] = 64'd3;
    beats[1] = 64'hFFFF_FFFF_FFFF_FFF6;
    beats[2] = 64'h7FFF_FFFF_0000_0000;
    beats[3] = 64'd5;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_product = beats[i]; a_in_last = (i == 3);
      step();
      if (i < 3) begin
        n_checks++;
        if (a_out_valid !== 1'b0) $display("FAIL b2b_early_valid: beat %0d got %b want 0", i, a_out_valid);
        else n_pass++;
      end
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_ovf, a_out_count} !== {1'b1, 1'b0, 8'd4}) $display("FAIL b2b_flags: got v=%b o=%b c=%0d want v=1 o=0 c=4", a_out_valid, a_out_ovf, a_out_count);
    else n_pass++;
    n_checks++;
    if (a_out_acc !== 72'h00_7FFF_FFFE_FFFF_FFFE) $display("FAIL b2b_acc: got %h want 007ffffffefffffffe", a_out_acc);
    else n_pass++;
    step();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid=%b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_hold_stall();
    logic [63:0] r;
    logic [71:0] r_x;
    r   = {$urandom, $urandom};
    r_x = {{8{r[63]}}, r};
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_product = r; a_in_last = 1'b1;
    step();
    a_in_product = 64'd7;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({a_in_ready, a_out_valid} !== 2'b01) $display("FAIL stall_hs: cycle %0d got in_ready=%b out_valid=%b want 0 1", k, a_in_ready, a_out_valid);
      else n_pass++;
      n_checks++;
      if ({a_out_acc, a_out_count} !== {r_x, 8'd1}) $display("FAIL stall_data: cycle %0d got acc=%h cnt=%0d want acc=%h cnt=1", k, a_out_acc, a_out_count, r_x);
      else n_pass++;
      step();
    end
    a_out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", a_in_ready);
    else n_pass++;
    step();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_acc, a_out_count} !== {1'b1, 72'd7, 8'd1}) $display("FAIL stall_next: got v=%b acc=%h cnt=%0d want v=1 acc=7 cnt=1", a_out_valid, a_out_acc, a_out_count);
    else n_pass++;
    step();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL stall_drain: got out_valid=%b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic signed [127:0] e_acc;
    logic                e_ovf, o;
    logic [63:0]         g2 [3];
    logic [63:0]         exp1;
`ifdef MAC_ACCUM_SATURATE_EN
    exp1 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp1 = 64'h8000_0000_0000_0000;
`endif
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_product = 64'h7FFF_FFFF_FFFF_FFFF; b_in_last = 1'b0;
    step();
    b_in_product = 64'd1; b_in_last = 1'b1;
    step();
    n_checks++;
    if ({b_out_valid, b_out_ovf, b_out_count} !== {1'b1, 1'b1, 8'd2}) $display("FAIL ovf_pos_flags: got v=%b o=%b c=%0d want v=1 o=1 c=2", b_out_valid, b_out_ovf, b_out_count);
    else n_pass++;
    n_checks++;
    if (b_out_acc !== exp1) $display("FAIL ovf_pos_acc: got %h want %h", b_out_acc, exp1);
    else n_pass++;
    // Negative overflow then a positive one; first beat drains group 1.
    g2[0] = 64'h8000_0000_0000_0000;
    g2[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    g2[2] = 64'd5;
    e_acc = '0; e_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_product = g2[i]; b_in_last = (i == 2);
      e_acc = m_add(e_acc, $signed(g2[i]), 64, o);
      e_ovf = e_ovf | o;
      step();
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    n_checks++;
    if ({b_out_valid, b_out_ovf, b_out_count} !== {1'b1, e_ovf, 8'd3}) $display("FAIL ovf_neg_flags: got v=%b o=%b c=%0d want v=1 o=%b c=3", b_out_valid, b_out_ovf, b_out_count, e_ovf);
    else n_pass++;
    n_checks++;
    if (b_out_acc !== e_acc[63:0]) $display("FAIL ovf_neg_acc: got %h want %h", b_out_acc, e_acc[63:0]);
    else n_pass++;
    step();
    b_in_valid = 1'b1; b_in_product = 64'd1; b_in_last = 1'b0;
    step();
    b_in_product = 64'd2; b_in_last = 1'b1;
    step();
    b_in_valid = 1'b0; b_in_last = 1'b0;
    n_checks++;
    if ({b_out_valid, b_out_ovf, b_out_acc} !== {1'b1, 1'b0, 64'd3}) $display("FAIL ovf_cleared: got v=%b o=%b acc=%h want v=1 o=0 acc=3", b_out_valid, b_out_ovf, b_out_acc);
    else n_pass++;
    step();
    b_out_ready = 1'b0;
  endtask

  task automatic test_forced_close();
    c_out_ready = 1'b1;
    c_in_valid = 1'b1; c_in_product = 64'd1; c_in_last = 1'b0;
    step();
    step();
    n_checks++;
    if (c_out_valid !== 1'b0) $display("FAIL force_early: got out_valid=%b want 0", c_out_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({c_out_valid, c_out_count, c_out_acc} !== {1'b1, 2'd3, 72'd3}) $display("FAIL force_close: got v=%b cnt=%0d acc=%h want v=1 cnt=3 acc=3", c_out_valid, c_out_count, c_out_acc);
    else n_pass++;
    c_in_product = 64'd4; c_in_last = 1'b1;
    step();
    c_in_valid = 1'b0; c_in_last = 1'b0;
    n_checks++;
    if ({c_out_valid, c_out_count, c_out_acc} !== {1'b1, 2'd1, 72'd4}) $display("FAIL force_next: got v=%b cnt=%0d acc=%h want v=1 cnt=1 acc=4", c_out_valid, c_out_count, c_out_acc);
    else n_pass++;
    step();
    c_out_ready = 1'b0;
    n_checks++;
    if (c_out_valid !== 1'b0) $display("FAIL force_drain: got out_valid=%b want 0", c_out_valid);
    else n_pass++;
  endtask

  // One clock of the random scenario: check, drive, advance, update model.
  task automatic random_cycle(input logic v, input logic rdy,
                              input logic [63:0] p, input logic last);
    logic acc_ok, drain, o;
    n_checks++;
    if (a_out_valid !== m_pend) $display("FAIL rnd_valid: got %b want %b", a_out_valid, m_pend);
    else n_pass++;
    if (m_pend) begin
      n_checks++;
      if ({a_out_count, a_out_ovf, a_out_acc} !== {r_cnt[7:0], r_ovf, r_acc[71:0]})
        $display("FAIL rnd_result: got cnt=%0d o=%b acc=%h want cnt=%0d o=%b acc=%h",
                 a_out_count, a_out_ovf, a_out_acc, r_cnt, r_ovf, r_acc[71:0]);
      else n_pass++;
    end
    a_in_valid = v; a_out_ready = rdy; a_in_product = p; a_in_last = last;
    #1;
    n_checks++;
    if (a_in_ready !== (!m_pend || rdy)) $display("FAIL rnd_ready: got %b want %b", a_in_ready, (!m_pend || rdy));
    else n_pass++;
    acc_ok = v && (!m_pend || rdy);
    drain  = m_pend && rdy;
    step();
    if (drain) m_pend = 1'b0;
    if (acc_ok) begin
      if (!m_open) begin
        m_acc = '0; m_cnt = 0; m_ovf = 1'b0; m_open = 1'b1;
      end
      m_acc = m_add(m_acc, $signed(p), 72, o);
      m_ovf = m_ovf | o;
      m_cnt++;
      if (last || m_cnt == 255) begin
        r_acc = m_acc; r_cnt = m_cnt; r_ovf = m_ovf;
        m_pend = 1'b1; m_open = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    m_open = 1'b0; m_pend = 1'b0;
    m_acc = '0; r_acc = '0; m_cnt = 0; r_cnt = 0; m_ovf = 1'b0; r_ovf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      random_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end
    if (m_open) random_cycle(1'b1, 1'b1, {$urandom, $urandom}, 1'b1);
    random_cycle(1'b0, 1'b1, 64'd0, 1'b0);
    random_cycle(1'b0, 1'b1, 64'd0, 1'b0);
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL rnd_end: got out_valid=%b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_product = 64'd11; a_in_last = 1'b0;
    step();
    a_in_product = 64'd22;
    step();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_count, a_out_acc} !== {8'd2, 72'd33}) $display("FAIL areset_pre: got cnt=%0d acc=%h want cnt=2 acc=21", a_out_count, a_out_acc);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_ovf, a_in_ready, a_out_count, a_out_acc} !== 83'h0) $display("FAIL areset_now: got v=%b r=%b cnt=%0d acc=%h want all 0", a_out_valid, a_in_ready, a_out_count, a_out_acc);
    else n_pass++;
    step();
    #2 rst_n = 1'b1;
    step();
    a_in_valid = 1'b1; a_in_product = 64'd9; a_in_last = 1'b1;
    step();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_count, a_out_acc} !== {1'b1, 8'd1, 72'd9}) $display("FAIL areset_after: got v=%b cnt=%0d acc=%h want v=1 cnt=1 acc=9", a_out_valid, a_out_count, a_out_acc);
    else n_pass++;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_stall();
    test_overflow();
    test_forced_close();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
